cr_lz77_comp_tile_seq: RTL
==========================

Name: cr_lz77_comp_tile_seq

Overview:
Frame-level sequencer for one LZ77 compare tile (chain). Accepts a prefix (history) stream and a data stream via valid/ready handshakes and generates the tile control strobes that load, shift and flush the tile. These strobes are input_en, shift_en, prefix_en, me_tile_enable, shift_start_phase, cl_ti_clr_valid and cl_ti_force_done. It sits between the compressor input FIFO/prefix fetch and the first tile of the compare array.

Parameters:
IN_BYTES, 4, bytes per beat on data/prefix buses
SHIFT_MULT, 4, modulus of shift_start_phase counter
CLR_CYCLES, 2, cycles cl_ti_clr_valid is held at frame start
DRAIN_CYCLES, 8, post-EOF cycles before force_done (pipeline depth of tile)

Ports:
clk  input  1  clock; sole clock domain
rst  input  1  reset; synchronous, active-high
cfg_prefix_en  input  1  frame uses prefix; sampled in IDLE on SOF detect
in_vld  input  1  data beat valid
in_ready  output  1  data beat accepted when in_vld&in_ready
in_data  input  IN_BYTES*8  data bytes, byte0 in [7:0]
in_bytes_vld  input  IN_BYTES  per-byte valid, contiguous from bit 0
in_sof  input  1  first beat of frame
in_eof  input  1  last beat of frame
pfx_vld  input  1  prefix beat valid
pfx_ready  output  1  prefix beat accepted when pfx_vld&pfx_ready
pfx_data  input  IN_BYTES*8  prefix bytes
pfx_last  input  1  last prefix beat
lz77_tile_data  output  IN_BYTES*8  registered data to tile
lz77_tile_data_vld  output  IN_BYTES  registered byte valids
lz77_tile_prefix_data  output  IN_BYTES*8  registered prefix to tile
lz77_tile_prefix_data_vld  output  IN_BYTES  registered prefix valids
input_en  output  1  data beat present this cycle
shift_en  output  1  tile history shift this cycle
prefix_en  output  1  prefix beat present this cycle
me_tile_enable  output  1  tile active (PREFIX/RUN/DRAIN)
shift_start_phase  output  $clog2(SHIFT_MULT)  phase of current shift
cl_ti_clr_valid  output  1  clear tile valid state
cl_ti_force_done  output  1  flush tile match state
frame_done  output  1  one-cycle pulse at end of frame
protocol_err  output  1  sticky error, cleared only by rst

Behaviour:
- All outputs registered; rst (sync, high) forces state IDLE and every output to 0, including protocol_err and shift_start_phase.
- States: IDLE, CLEAR, PREFIX, RUN, DRAIN.
- IDLE: in_ready=pfx_ready=0. in_vld&in_sof observed (not consumed) -> CLEAR; latch cfg_prefix_en. in_vld without in_sof -> protocol_err=1; beat is not consumed.
- CLEAR: cl_ti_clr_valid=1 for exactly CLR_CYCLES cycles; shift_start_phase reset to 0. Then -> PREFIX if latched cfg_prefix_en, else RUN.
- PREFIX: pfx_ready=1, in_ready=0.
  - Accepted beat -> next cycle prefix_en=1, shift_en=1, prefix data/vld registered.
  - pfx_bytes must be full; prefix_data_vld is driven all ones.
  - Accepted pfx_last -> RUN.
  - in_vld ignored.
- RUN: in_ready=1, pfx_ready=0.
  - Accepted beat -> next cycle input_en=1, shift_en=1, lz77_tile_data/_vld = beat; shift_start_phase increments mod SHIFT_MULT after each shift.
  - No beat -> input_en=shift_en=0; data_vld=0; phase holds.
  - Accepted in_eof -> DRAIN.
  - Errors, flagged via protocol_err=1 while the beat is still passed: in_sof on a non-first beat; non-contiguous in_bytes_vld; partial in_bytes_vld on a non-eof beat; in_bytes_vld=0.
- DRAIN: in_ready=pfx_ready=0, input_en=shift_en=0, me_tile_enable=1. Counter runs DRAIN_CYCLES cycles. cl_ti_force_done=1 and frame_done=1 on the final drain cycle. Next state is IDLE.
- me_tile_enable=1 in PREFIX, RUN, DRAIN; 0 in IDLE, CLEAR.
- Latency: handshake cycle N -> strobes/data at N+1. Back-to-back beats give continuous input_en.
- Mid-frame rst: immediate return to IDLE; no force_done and no frame_done are issued.
- Phase counter wraps SHIFT_MULT-1 -> 0.

Test Plan:
- cfg_prefix_en=0; SOF beat with 3 further full beats, EOF on 4th. Expect: clr_valid high 2 cycles; input_en high 4 consecutive cycles; shift_start_phase 0,1,2,3 then wraps to 0; 8 drain cycles; force_done and frame_done pulse together; return to IDLE.
- cfg_prefix_en=1; 2 prefix beats (pfx_last on 2nd), with in_vld held high throughout. Expect: prefix_en 2 cycles with in_ready=0, then RUN accepts data.
- EOF beat with in_bytes_vld=4'b0011. Expect: lz77_tile_data_vld=4'b0011, protocol_err=0. A separate non-eof beat with 4'b0101 -> protocol_err=1.
- in_vld toggling 1,0,1 in RUN. Expect: input_en 1,0,1; phase advances only on shifts.
- rst asserted during DRAIN cycle 3. Expect: next cycle all outputs 0, frame_done never pulses.
- in_vld without sof in IDLE. Expect: protocol_err=1, in_ready stays 0.

Source files
------------

// File: rtl/cr_lz77_comp_tile_seq.sv
// Frame sequencer for one LZ77 compare tile: handshakes prefix/data streams and
// produces the registered load/shift/clear/flush strobes for the tile chain.
module cr_lz77_comp_tile_seq #(
    parameter int IN_BYTES     = 4,
    parameter int SHIFT_MULT   = 4,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_prefix_en,
    input  logic                          in_vld,
    output logic                          in_ready,
    input  logic [IN_BYTES*8-1:0]         in_data,
    input  logic [IN_BYTES-1:0]           in_bytes_vld,
    input  logic                          in_sof,
    input  logic                          in_eof,
    input  logic                          pfx_vld,
    output logic                          pfx_ready,
    input  logic [IN_BYTES*8-1:0]         pfx_data,
    input  logic                          pfx_last,
    output logic [IN_BYTES*8-1:0]         lz77_tile_data,
    output logic [IN_BYTES-1:0]           lz77_tile_data_vld,
    output logic [IN_BYTES*8-1:0]         lz77_tile_prefix_data,
    output logic [IN_BYTES-1:0]           lz77_tile_prefix_data_vld,
    output logic                          input_en,
    output logic                          shift_en,
    output logic                          prefix_en,
    output logic                          me_tile_enable,
    output logic [$clog2(SHIFT_MULT)-1:0] shift_start_phase,
    output logic                          cl_ti_clr_valid,
    output logic                          cl_ti_force_done,
    output logic                          frame_done,
    output logic                          protocol_err
);

    localparam int PW   = $clog2(SHIFT_MULT);
    localparam int CMAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(SHIFT_MULT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PREFIX, S_RUN, S_DRAIN} state_t;

    state_t                 r_state, w_nxt_state;
    logic [CW-1:0]          r_cnt, w_nxt_cnt;
    logic                   r_use_pfx, r_first, w_err_set;
    logic                   r_in_ready, r_pfx_ready, r_input_en, r_shift_en, r_prefix_en;
    logic                   r_me, r_clr, r_force, r_done, r_err;
    logic [PW-1:0]          r_phase;
    logic [IN_BYTES*8-1:0]  r_data, r_pdata;
    logic [IN_BYTES-1:0]    r_dvld, r_pvld;
    logic                   w_in_acc, w_pfx_acc, w_beat_bad;

    assign w_in_acc  = in_vld & r_in_ready;
    assign w_pfx_acc = pfx_vld & r_pfx_ready;

    // byte valids must be a run of ones from bit 0 and non-empty; only the eof beat may be partial
    assign w_beat_bad = (in_sof & ~r_first)
                      | ((in_bytes_vld & (in_bytes_vld + 1'b1)) != '0)
                      | (~in_eof & (in_bytes_vld != '1))
                      | (in_bytes_vld == '0);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_vld) begin
                    if (in_sof) begin
                        w_nxt_state = S_CLEAR;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (r_cnt == CLR_LAST) w_nxt_state = r_use_pfx ? S_PREFIX : S_RUN;
                else                   w_nxt_cnt   = r_cnt + 1'b1;
            end
            S_PREFIX: begin
                if (w_pfx_acc && pfx_last) w_nxt_state = S_RUN;
            end
            S_RUN: begin
                if (w_in_acc) begin
                    w_err_set = w_beat_bad;
                    if (in_eof) begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_cnt   = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_nxt_state = S_IDLE;
                else                     w_nxt_cnt   = r_cnt + 1'b1;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // control outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_use_pfx   <= 1'b0;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_pfx_ready <= 1'b0;
            r_input_en  <= 1'b0;
            r_shift_en  <= 1'b0;
            r_prefix_en <= 1'b0;
            r_me        <= 1'b0;
            r_clr       <= 1'b0;
            r_force     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_phase     <= '0;
            r_data      <= '0;
            r_pdata     <= '0;
            r_dvld      <= '0;
            r_pvld      <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            if (r_state == S_IDLE && in_vld && in_sof) r_use_pfx <= cfg_prefix_en;
            if (r_state == S_IDLE && w_nxt_state == S_CLEAR) r_first <= 1'b1;
            else if (w_in_acc)                               r_first <= 1'b0;
            r_err       <= r_err | w_err_set;
            r_in_ready  <= (w_nxt_state == S_RUN);
            r_pfx_ready <= (w_nxt_state == S_PREFIX);
            r_me        <= (w_nxt_state == S_PREFIX) || (w_nxt_state == S_RUN) ||
                           (w_nxt_state == S_DRAIN);
            r_clr       <= (w_nxt_state == S_CLEAR);
            r_force     <= (w_nxt_state == S_DRAIN) && (w_nxt_cnt == DRAIN_LAST);
            r_done      <= (w_nxt_state == S_DRAIN) && (w_nxt_cnt == DRAIN_LAST);
            r_input_en  <= w_in_acc;
            r_prefix_en <= w_pfx_acc;
            r_shift_en  <= w_in_acc | w_pfx_acc;
            if (w_in_acc) begin
                r_data <= in_data;
                r_dvld <= in_bytes_vld;
            end else begin
                r_dvld <= '0;
            end
            if (w_pfx_acc) begin
                r_pdata <= pfx_data;
                r_pvld  <= '1;
            end else begin
                r_pvld  <= '0;
            end
            if (w_nxt_state == S_CLEAR) r_phase <= '0;
            else if (r_shift_en)        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    assign in_ready                  = r_in_ready;
    assign pfx_ready                 = r_pfx_ready;
    assign lz77_tile_data            = r_data;
    assign lz77_tile_data_vld        = r_dvld;
    assign lz77_tile_prefix_data     = r_pdata;
    assign lz77_tile_prefix_data_vld = r_pvld;
    assign input_en                  = r_input_en;
    assign shift_en                  = r_shift_en;
    assign prefix_en                 = r_prefix_en;
    assign me_tile_enable            = r_me;
    assign shift_start_phase         = r_phase;
    assign cl_ti_clr_valid           = r_clr;
    assign cl_ti_force_done          = r_force;
    assign frame_done                = r_done;
    assign protocol_err              = r_err;

endmodule
